// File: rtl/controller.sv
`default_nettype none
// ============================================================================
// Module   : controller
// Purpose  : Multicycle control FSM for the 16-bit processor core. Decodes the
//            IR and PSR flags and drives every datapath enable and mux select,
//            one state per clock.
// Revision : 1.0 - initial release
// ============================================================================
module controller #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] instr,
   input  logic [4:0]       flags,        // {C, L, F, N, Z}
   output logic             irwrite,
   output logic             regwrite,
   output logic             memwrite,
   output logic             psr_write,
   output logic             pcen,
   output logic             wa_s,
   output logic             pc_s,
   output logic             alub_s,
   output logic             mem_s,
   output logic [1:0]       wd_s,
   output logic [1:0]       alua_s,
   output logic             signext_sign,
   output logic [2:0]       alucont
);

   localparam logic [2:0] C_ALU_ADD = 3'b000;
   localparam logic [2:0] C_ALU_SUB = 3'b001;
   localparam logic [2:0] C_ALU_AND = 3'b010;
   localparam logic [2:0] C_ALU_OR  = 3'b011;
   localparam logic [2:0] C_ALU_XOR = 3'b100;

   typedef enum logic [3:0] {
      S_FETCH  = 4'd0,
      S_IRLOAD = 4'd1,
      S_DECODE = 4'd2,
      S_RTYPE  = 4'd3,
      S_ITYPE  = 4'd4,
      S_LDADDR = 4'd5,
      S_LDWB   = 4'd6,
      S_STORE  = 4'd7,
      S_JUMP   = 4'd8
   } state_t;

   // Controls implied by one ALU function code (shared by RTYPE ext and ITYPE op)
   typedef struct packed {
      logic       legal;
      logic [2:0] alu;
      logic       wr;      // register write (also selects rd as write address)
      logic       psr;     // updates the flags
      logic [1:0] wd;      // write-data select for the register form
      logic       sx;      // immediate form sign-extends
   } fn_t;

   function automatic fn_t decode_fn(input logic [3:0] code);
      fn_t f;
      f = '0;
      case (code)
         4'b0101: begin f.legal = 1'b1; f.alu = C_ALU_ADD; f.wr = 1'b1; f.psr = 1'b1; f.wd = 2'b11; f.sx = 1'b1; end
         4'b1001: begin f.legal = 1'b1; f.alu = C_ALU_SUB; f.wr = 1'b1; f.psr = 1'b1; f.wd = 2'b11; f.sx = 1'b1; end
         4'b0001: begin f.legal = 1'b1; f.alu = C_ALU_AND; f.wr = 1'b1; f.wd = 2'b11; end
         4'b0010: begin f.legal = 1'b1; f.alu = C_ALU_OR;  f.wr = 1'b1; f.wd = 2'b11; end
         4'b0011: begin f.legal = 1'b1; f.alu = C_ALU_XOR; f.wr = 1'b1; f.wd = 2'b11; end
         4'b1011: begin f.legal = 1'b1; f.alu = C_ALU_SUB; f.psr = 1'b1; f.sx = 1'b1; end   // CMP
         4'b1101: begin f.legal = 1'b1; f.wr = 1'b1; f.wd = 2'b01; end                      // MOV
         default: f = '0;
      endcase
      return f;
   endfunction

   // Branch condition selected by the rd field
   function automatic logic cond_true(input logic [3:0] c, input logic [4:0] fl);
      logic cf, lf, ff, nf, zf;
      logic r;
      {cf, lf, ff, nf, zf} = fl;
      case (c)
         4'h0: r = zf;
         4'h1: r = ~zf;
         4'h2: r = cf;
         4'h3: r = ~cf;
         4'h4: r = lf;
         4'h5: r = ~lf;
         4'h6: r = nf;
         4'h7: r = ~nf;
         4'h8: r = ff;
         4'h9: r = ~ff;
         4'hA: r = ~lf & ~zf;
         4'hB: r = lf | zf;
         4'hC: r = ~nf & ~zf;
         4'hD: r = nf | zf;
         4'hE: r = 1'b1;
         default: r = 1'b0;
      endcase
      return r;
   endfunction

   state_t     state_q, state_d;
   logic [3:0] w_op, w_rd, w_ext;
   fn_t        w_fn_op, w_fn_ext;
   logic       w_unused_rs;

   assign w_op        = instr[15:12];
   assign w_rd        = instr[11:8];
   assign w_ext       = instr[7:4];
   assign w_unused_rs = ^instr[3:0];
   assign w_fn_op     = decode_fn(w_op);
   assign w_fn_ext    = decode_fn(w_ext);

   // State register; reset returns to FETCH
   always_ff @(posedge clk) begin
      if (reset) state_q <= S_FETCH;
      else       state_q <= state_d;
   end

   // Next-state and output decode; reset forces every output to idle
   always_comb begin
      state_d      = state_q;
      irwrite      = 1'b0;
      regwrite     = 1'b0;
      memwrite     = 1'b0;
      psr_write    = 1'b0;
      pcen         = 1'b0;
      wa_s         = 1'b0;
      pc_s         = 1'b0;
      alub_s       = 1'b0;
      mem_s        = 1'b0;
      wd_s         = 2'b00;
      alua_s       = 2'b00;
      signext_sign = 1'b0;
      alucont      = C_ALU_ADD;

      case (state_q)
         S_FETCH: begin
            // PC <- PC + 1 while the instruction read is issued at PC
            mem_s   = 1'b1;
            alua_s  = 2'b01;
            alub_s  = 1'b1;
            alucont = C_ALU_ADD;
            pc_s    = 1'b1;
            pcen    = 1'b1;
            state_d = S_IRLOAD;
         end
         S_IRLOAD: begin
            irwrite = 1'b1;
            state_d = S_DECODE;
         end
         S_DECODE: begin
            if (w_op == 4'b0000 && w_fn_ext.legal) state_d = S_RTYPE;
            else if (w_fn_op.legal)                 state_d = S_ITYPE;
            else if (w_op == 4'b0100) begin
               case (w_ext)
                  4'b0000: state_d = S_LDADDR;
                  4'b0100: state_d = S_STORE;
                  4'b1100: state_d = S_JUMP;
                  default: state_d = S_FETCH;
               endcase
            end
            else state_d = S_FETCH;
         end
         S_RTYPE: begin
            alucont   = w_fn_ext.alu;
            regwrite  = w_fn_ext.wr;
            wa_s      = w_fn_ext.wr;
            psr_write = w_fn_ext.psr;
            wd_s      = w_fn_ext.wd;
            state_d   = S_FETCH;
         end
         S_ITYPE: begin
            alua_s       = 2'b10;
            alucont      = w_fn_op.alu;
            regwrite     = w_fn_op.wr;
            wa_s         = w_fn_op.wr;
            psr_write    = w_fn_op.psr;
            signext_sign = w_fn_op.sx;
            // MOVI writes the immediate itself rather than the Rsrc register
            wd_s         = (w_op == 4'b1101) ? 2'b00 : w_fn_op.wd;
            state_d      = S_FETCH;
         end
         S_LDADDR: begin
            mem_s   = 1'b0;
            state_d = S_LDWB;
         end
         S_LDWB: begin
            wd_s     = 2'b10;
            wa_s     = 1'b1;
            regwrite = 1'b1;
            state_d  = S_FETCH;
         end
         S_STORE: begin
            mem_s    = 1'b0;
            memwrite = 1'b1;
            state_d  = S_FETCH;
         end
         S_JUMP: begin
            pc_s    = 1'b0;
            pcen    = cond_true(w_rd, flags);
            state_d = S_FETCH;
         end
         default: state_d = S_FETCH;
      endcase

      if (reset) begin
         irwrite      = 1'b0;
         regwrite     = 1'b0;
         memwrite     = 1'b0;
         psr_write    = 1'b0;
         pcen         = 1'b0;
         wa_s         = 1'b0;
         pc_s         = 1'b0;
         alub_s       = 1'b0;
         mem_s        = 1'b0;
         wd_s         = 2'b00;
         alua_s       = 2'b00;
         signext_sign = 1'b0;
         alucont      = C_ALU_ADD;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_controller
// Purpose  : Self-checking bench for controller. A per-instruction model
//            produces the expected output vector for every cycle; one compare
//            process checks the DUT on each falling edge, and literal checks
//            pin key cycles of the model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_controller;

   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] instr;
   logic [4:0]  flags;
   logic        irwrite, regwrite, memwrite, psr_write, pcen;
   logic        wa_s, pc_s, alub_s, mem_s, signext_sign;
   logic [1:0]  wd_s, alua_s;
   logic [2:0]  alucont;

   always #5 clk = ~clk;

   controller #(.WIDTH(16)) dut (
      .clk(clk), .reset(reset), .instr(instr), .flags(flags),
      .irwrite(irwrite), .regwrite(regwrite), .memwrite(memwrite),
      .psr_write(psr_write), .pcen(pcen), .wa_s(wa_s), .pc_s(pc_s),
      .alub_s(alub_s), .mem_s(mem_s), .wd_s(wd_s), .alua_s(alua_s),
      .signext_sign(signext_sign), .alucont(alucont)
   );

   typedef struct packed {
      logic       irwrite, regwrite, memwrite, psr_write, pcen;
      logic       wa_s, pc_s, alub_s, mem_s;
      logic [1:0] wd_s, alua_s;
      logic       signext_sign;
      logic [2:0] alucont;
   } ov_t;

   ov_t dut_v;
   assign dut_v = {irwrite, regwrite, memwrite, psr_write, pcen, wa_s, pc_s,
                   alub_s, mem_s, wd_s, alua_s, signext_sign, alucont};

   ov_t exp_q[$];
   ov_t obs_q[$];
   int  n_checks = 0;
   int  n_fail   = 0;

   // ALU function table: ADD SUB AND OR XOR CMP MOV
   logic [3:0] code_tab[7] = '{4'h5, 4'h9, 4'h1, 4'h2, 4'h3, 4'hB, 4'hD};
   int         alu_tab[7]  = '{0, 1, 2, 3, 4, 1, 0};

   function automatic int fn_index(input logic [3:0] code);
      for (int i = 0; i < 7; i++) if (code_tab[i] == code) return i;
      return -1;
   endfunction

   function automatic bit cond_ok(input logic [3:0] c, input logic [4:0] fl);
      bit cf, lf, ff, nf, zf;
      cf = fl[4]; lf = fl[3]; ff = fl[2]; nf = fl[1]; zf = fl[0];
      case (c)
         4'h0: return zf;            4'h1: return !zf;
         4'h2: return cf;            4'h3: return !cf;
         4'h4: return lf;            4'h5: return !lf;
         4'h6: return nf;            4'h7: return !nf;
         4'h8: return ff;            4'h9: return !ff;
         4'hA: return !lf && !zf;    4'hB: return lf || zf;
         4'hC: return !nf && !zf;    4'hD: return nf || zf;
         4'hE: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   // Expected execute-cycle vector for an ALU-class instruction
   function automatic ov_t alu_vec(input int idx, input bit imm);
      ov_t v;
      v = '0;
      v.alucont   = 3'(alu_tab[idx]);
      v.regwrite  = (idx != 5);
      v.wa_s      = (idx != 5);
      v.psr_write = (idx == 0 || idx == 1 || idx == 5);
      if (idx == 6)      v.wd_s = imm ? 2'b00 : 2'b01;
      else if (idx != 5) v.wd_s = 2'b11;
      if (imm) begin
         v.alua_s       = 2'b10;
         v.signext_sign = (idx == 0 || idx == 1 || idx == 5);
      end
      return v;
   endfunction

   // Push the full cycle-by-cycle expectation of one instruction
   task automatic model_instr(input logic [15:0] ins, input logic [4:0] fl, output int n);
      ov_t v;
      logic [3:0] op, rd, ext;
      op = ins[15:12]; rd = ins[11:8]; ext = ins[7:4];
      v = '0; v.mem_s = 1; v.alua_s = 2'b01; v.alub_s = 1; v.pc_s = 1; v.pcen = 1;
      exp_q.push_back(v);                    // fetch
      v = '0; v.irwrite = 1;
      exp_q.push_back(v);                    // IR load
      exp_q.push_back(ov_t'(0));             // decode
      n = 3;
      if (op == 4'h0 && fn_index(ext) >= 0) begin
         exp_q.push_back(alu_vec(fn_index(ext), 1'b0)); n = 4;
      end else if (fn_index(op) >= 0) begin
         exp_q.push_back(alu_vec(fn_index(op), 1'b1)); n = 4;
      end else if (op == 4'h4 && ext == 4'h0) begin
         exp_q.push_back(ov_t'(0));
         v = '0; v.wd_s = 2'b10; v.wa_s = 1; v.regwrite = 1;
         exp_q.push_back(v); n = 5;
      end else if (op == 4'h4 && ext == 4'h4) begin
         v = '0; v.memwrite = 1;
         exp_q.push_back(v); n = 4;
      end else if (op == 4'h4 && ext == 4'hC) begin
         v = '0; v.pcen = cond_ok(rd, fl);
         exp_q.push_back(v); n = 4;
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic run(input logic [15:0] ins, input logic [4:0] fl, output int n);
      obs_q.delete();
      instr = ins;
      flags = fl;
      model_instr(ins, fl, n);
      step(n);
   endtask

   // Compare DUT outputs against the model every cycle an expectation exists
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         ov_t e;
         e = exp_q.pop_front();
         n_checks++;
         if (dut_v !== e) begin
            n_fail++;
            $display("FAIL cycle_vector t=%0t instr=%h: got %h expected %h", $time, instr, dut_v, e);
         end
         obs_q.push_back(dut_v);
      end
   end

   logic [4:0] fl_pat[7] = '{5'b00000, 5'b11111, 5'b00001, 5'b00010, 5'b01000, 5'b10100, 5'b00110};

   initial begin
      int n;
      reset = 1'b1;
      instr = 16'h0000;
      flags = 5'b0;
      step(1);

      // Reset held three observed cycles: everything idle
      obs_q.delete();
      repeat (3) exp_q.push_back(ov_t'(0));
      step(3);
      for (int i = 0; i < 3; i++) begin
         chk("rst_pcen", obs_q[i].pcen, 0);
         chk("rst_mem_s", obs_q[i].mem_s, 0);
      end
      reset = 1'b0;

      // ADD r3,r2
      run(16'h0352, 5'b0, n);
      chk("add_len", n, 4);
      chk("fetch_pcen", obs_q[0].pcen, 1);
      chk("fetch_mem_s", obs_q[0].mem_s, 1);
      chk("fetch_alucont", obs_q[0].alucont, 0);
      chk("irload_irwrite", obs_q[1].irwrite, 1);
      chk("add_regwrite", obs_q[3].regwrite, 1);
      chk("add_wd_s", obs_q[3].wd_s, 3);
      chk("add_alucont", obs_q[3].alucont, 0);
      chk("add_psr", obs_q[3].psr_write, 1);
      chk("add_c3_regwrite", obs_q[2].regwrite, 0);

      // SUBI / ANDI
      run(16'h93F0, 5'b0, n);
      chk("add_then_fetch", obs_q[0].pcen, 1);
      chk("subi_sx", obs_q[3].signext_sign, 1);
      chk("subi_alua", obs_q[3].alua_s, 2);
      chk("subi_alucont", obs_q[3].alucont, 1);
      run(16'h13F0, 5'b0, n);
      chk("andi_sx", obs_q[3].signext_sign, 0);
      chk("andi_alucont", obs_q[3].alucont, 2);

      // LOAD r5,[r2]
      run(16'h4502, 5'b0, n);
      chk("load_len", n, 5);
      chk("load_mem_s", obs_q[3].mem_s, 0);
      chk("ldwb_wd_s", obs_q[4].wd_s, 2);
      chk("ldwb_regwrite", obs_q[4].regwrite, 1);
      for (int i = 0; i < 5; i++) chk("load_memwrite", obs_q[i].memwrite, 0);

      // JEQ r4 with Z set / clear
      run(16'h40C4, 5'b00001, n);
      chk("jeq_taken_pcen", obs_q[3].pcen, 1);
      chk("jeq_pc_s", obs_q[3].pc_s, 0);
      run(16'h40C4, 5'b00000, n);
      chk("jeq_not_taken_pcen", obs_q[3].pcen, 0);

      // All condition codes against several flag patterns
      for (int c = 0; c < 16; c++)
         for (int p = 0; p < 7; p++)
            run({4'h4, 4'(c), 4'hC, 4'h4}, fl_pat[p], n);

      // Every register and immediate ALU form, store, and a few undefined ops
      for (int i = 0; i < 7; i++) begin
         run({4'h0, 4'h3, code_tab[i], 4'h2}, 5'b0, n);
         run({code_tab[i], 4'h3, 8'hA5}, 5'b0, n);
      end
      run(16'h4347, 5'b0, n);
      chk("store_memwrite", obs_q[3].memwrite, 1);
      run(16'h0070, 5'b0, n);
      run(16'h6000, 5'b0, n);
      run(16'hF123, 5'b0, n);

      // Undefined ext under op 0100 is a 3-cycle NOP
      run(16'h4070, 5'b0, n);
      chk("nop_len", n, 3);
      for (int i = 0; i < 3; i++) begin
         chk("nop_regwrite", obs_q[i].regwrite, 0);
         chk("nop_memwrite", obs_q[i].memwrite, 0);
      end
      run(16'h0352, 5'b0, n);
      chk("nop_then_fetch", obs_q[0].pcen, 1);

      // Load aborted by reset in its write-back cycle
      obs_q.delete();
      instr = 16'h4502;
      flags = 5'b0;
      model_instr(16'h4502, 5'b0, n);
      void'(exp_q.pop_back());
      exp_q.push_back(ov_t'(0));
      step(4);
      reset = 1'b1;
      step(1);
      reset = 1'b0;
      chk("abort_regwrite", obs_q[4].regwrite, 0);
      chk("abort_wd_s", obs_q[4].wd_s, 0);
      run(16'h0352, 5'b0, n);
      chk("abort_then_fetch", obs_q[0].pcen, 1);
      chk("abort_then_add", obs_q[3].regwrite, 1);

      chk("queue_drained", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/controller.md
# controller

Multicycle control FSM for the 16-bit processor core. It decodes the instruction register contents and the PSR flags, and drives every enable and mux select of the datapath, one state per clock. It sits beside the datapath, consuming the instruction and flags and sourcing all datapath control inputs.

## Interface
- WIDTH, 16, instruction width
- flags order, fixed: {C, L, F, N, Z}
- clk  input  1  system clock; all state changes on rising edge
- reset  input  1  synchronous, active-high
- instr  input  16  IR contents; valid from DECODE onward; fields op=[15:12], rd=[11:8], ext=[7:4], rs=[3:0], imm8=[7:0]
- flags  input  5  PSR flags {C,L,F,N,Z}
- irwrite, regwrite, memwrite, psr_write, pcen  output  1 each  write enables
- wa_s, pc_s, alub_s, mem_s  output  1 each  mux2 selects
- wd_s, alua_s  output  2 each  mux4 selects
- signext_sign  output  1  1 = sign-extend imm8, 0 = zero-extend imm8
- alucont  output  3  000 ADD (A+B), 001 SUB (B−A), 010 AND, 011 OR, 100 XOR

## Operation
- Mux encodings:
  - wa_s: 1 selects the rd field.
  - mem_s: 0 = Rsrc register, 1 = PC.
  - wd_s: 00 imm, 01 Rsrc, 10 mem_out, 11 alu_out.
  - pc_s: 0 = Rsrc, 1 = alu_out.
  - alua_s: 00 Rsrc, 01 PC, 10 imm_ext, 11 zero.
  - alub_s: 0 = Rdest, 1 = constant one.
- Outputs are a combinational function of the state register and instr (Moore with instruction qualification).
- Idle values, used in any state or field not listed below: every enable 0, every select 0, alucont 000, signext_sign 0.
- States and their actions:
  - FETCH: mem_s=1, alua_s=01, alub_s=1, alucont=ADD, pc_s=1, pcen=1 (PC←PC+1). Go to IRLOAD.
  - IRLOAD: irwrite=1. Go to DECODE.
  - DECODE: register operands latch in the datapath; no enables. Next state:
    - op=0000 with a legal ext → RTYPE.
    - op ∈ {0001, 0010, 0011, 0101, 1001, 1011, 1101} → ITYPE.
    - op=0100 with ext=0000 → LDADDR.
    - op=0100 with ext=0100 → STORE.
    - op=0100 with ext=1100 → JUMP.
    - Anything else → FETCH (treated as NOP).
  - RTYPE: alua_s=00, alub_s=0.
    - ext 0101 ADD, 1001 SUB, 0001 AND, 0010 OR, 0011 XOR: wd_s=11, wa_s=1, regwrite=1, psr_write=1 for ADD/SUB only.
    - ext 1011 CMP: alucont=SUB, psr_write=1, regwrite=0.
    - ext 1101 MOV: wd_s=01, wa_s=1, regwrite=1.
    - Next: FETCH.
  - ITYPE: same opcode→function mapping as the RTYPE ext codes, but with alua_s=10.
    - signext_sign=1 for 0101, 1001, 1011; 0 otherwise.
    - MOVI (1101): wd_s=00, regwrite=1.
    - Next: FETCH.
  - LDADDR: mem_s=0 (read address issued). Go to LDWB.
  - LDWB: wd_s=10, wa_s=1, regwrite=1. Go to FETCH.
  - STORE: mem_s=0, memwrite=1 (data = Rdest register). Go to FETCH.
  - JUMP: pc_s=0; pcen = cond(rd field, flags). Go to FETCH.
- Conditions, indexed by rd:
  - 0 EQ Z; 1 NE !Z; 2 CS C; 3 CC !C; 4 HI L; 5 LS !L; 6 GT N; 7 LE !N.
  - 8 FS F; 9 FC !F; A LO !L&!Z; B HS L|Z; C LT !N&!Z; D GE N|Z; E UC 1; F never 0.
- Undefined ext under op 0000 or 0100 → DECODE returns to FETCH with no writes.

## Timing
- Reset high: state←FETCH on the next edge; while reset is asserted, all outputs are forced to idle values regardless of state.
- Reset asserted mid-instruction aborts it; no enable is high in the reset cycle.
- First FETCH outputs appear in the first cycle with reset low.
- Cycle counts, FETCH to FETCH:
  - RTYPE, ITYPE, STORE, JUMP: 4 cycles.
  - LOAD: 5 cycles.
  - NOP/undefined: 3 cycles.
- At most one of regwrite/memwrite is high per cycle; pcen is high only in FETCH and in JUMP with a true condition.
- Memory is a synchronous read: the address is applied in FETCH/LDADDR, and data is consumed in IRLOAD/LDWB.
- Flags are sampled in the JUMP cycle only.

## Test plan
- Reset held 3 cycles, then released → idle outputs throughout reset; FETCH outputs (pcen=1, mem_s=1, alucont=000) on the first cycle after release; IRLOAD next.
- instr=0x0352 (ADD r3,r2) → regwrite=1, wd_s=11, alucont=000, psr_write=1 exactly in cycle 4, then FETCH.
- instr=0x93F0 (SUBI r3,#-16) → signext_sign=1, alua_s=10, alucont=001 in cycle 4; instr=0x13F0 (ANDI) → signext_sign=0, alucont=010.
- instr=0x4502 (LOAD r5,[r2]) → mem_s=0 in cycle 4; wd_s=10 with regwrite=1 in cycle 5; memwrite stays 0.
- instr=0x40C4 (JEQ r4): flags Z=1 → pcen=1, pc_s=0 in cycle 4; flags Z=0 → pcen=0. Sweep all 16 cond codes.
- instr=0x4070 (undefined ext), then reset asserted during LDWB → NOP returns to FETCH after 3 cycles with no writes; aborted load produces no regwrite.
